// File: rtl/video_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : video_write_arbiter
//  Purpose  : Shares the single video-memory write port between the core's
//             video store path and a linear fill engine. Core stores can
//             never stall, so they land in a small FIFO. A scheduler then
//             interleaves FIFO drains with fill writes. The core wins a tie
//             when the FIFO is at or above HIGH_WATER. Otherwise ties
//             alternate between the two requesters.
//  Ports    : clk, rst (async, active-low)
//             core_addr/core_data/core_we  - core store stream (no backpressure)
//             fill_start/base/count/data   - fill command, sampled in IDLE
//             fill_busy, fill_done         - fill status
//             core_overflow                - sticky dropped-store flag
//             vm_addr/vm_data/vm_we        - registered memory write port
//  Revision : 1.0 - initial release
// ============================================================================
module video_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int HIGH_WATER = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_data,
    input  logic        core_we,
    input  logic        fill_start,
    input  logic [31:0] fill_base,
    input  logic [15:0] fill_count,
    input  logic [31:0] fill_data,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        core_overflow,
    output logic [31:0] vm_addr,
    output logic [31:0] vm_data,
    output logic        vm_we
);

    localparam int            c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0] c_HW      = (c_AW + 1)'(HIGH_WATER);
    localparam logic [c_AW:0] c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0] c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Core store FIFO: {addr, data} entries
    // ------------------------------------------------------------------
    logic [63:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic [63:0]     w_head;

    // Fill engine
    state_t          r_state;
    logic [31:0]     r_cur_addr;
    logic [15:0]     r_remaining;
    logic [31:0]     r_value;

    // Arbitration
    logic            r_last_fill;
    logic            w_core_req;
    logic            w_fill_req;
    logic            w_grant_core;
    logic            w_grant_fill;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = w_grant_core;
    // A push into a full FIFO is safe when the head leaves in the same cycle.
    assign w_push  = core_we && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    // Storage needs no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {core_addr, core_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (core_we && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_core_req = !w_empty;
    assign w_fill_req = (r_state == S_RUN);

    always_comb begin
        w_grant_core = 1'b0;
        w_grant_fill = 1'b0;
        if (w_core_req && w_fill_req) begin
            // Near-full FIFO must drain or a later store could be lost.
            if ((r_count >= c_HW) || r_last_fill) begin
                w_grant_core = 1'b1;
            end else begin
                w_grant_fill = 1'b1;
            end
        end else if (w_core_req) begin
            w_grant_core = 1'b1;
        end else if (w_fill_req) begin
            w_grant_fill = 1'b1;
        end
    end

    // Reset value "fill" lets the core win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_fill <= 1'b1;
        end else if (w_grant_core || w_grant_fill) begin
            r_last_fill <= w_grant_fill;
        end
    end

    // ------------------------------------------------------------------
    // Fill engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_value     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fill_start) begin
                        r_cur_addr  <= fill_base;
                        r_remaining <= fill_count;
                        r_value     <= fill_data;
                        r_state     <= (fill_count != 16'd0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (w_grant_fill) begin
                        r_cur_addr  <= r_cur_addr + 32'd4;
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fill_busy     = (r_state != S_IDLE);
    assign fill_done     = (r_state == S_DONE);
    assign core_overflow = r_overflow;

    // ------------------------------------------------------------------
    // Registered memory write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vm_we   <= 1'b0;
            vm_addr <= '0;
            vm_data <= '0;
        end else begin
            vm_we <= w_grant_core || w_grant_fill;
            if (w_grant_core) begin
                vm_addr <= w_head[63:32];
                vm_data <= w_head[31:0];
            end else if (w_grant_fill) begin
                vm_addr <= r_cur_addr;
                vm_data <= r_value;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_write_arbiter
//  Purpose  : Directed, table-driven bench for video_write_arbiter. Each
//             row gives one cycle of inputs and the outputs expected in
//             that same cycle. Short loops cover interleaving and
//             asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_write_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] core_addr;
    logic [31:0] core_data;
    logic        core_we;
    logic        fill_start;
    logic [31:0] fill_base;
    logic [15:0] fill_count;
    logic [31:0] fill_data;
    logic        fill_busy;
    logic        fill_done;
    logic        core_overflow;
    logic [31:0] vm_addr;
    logic [31:0] vm_data;
    logic        vm_we;

    int checks = 0;
    int errors = 0;

    video_write_arbiter #(.FIFO_DEPTH(4), .HIGH_WATER(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_addr    (core_addr),
        .core_data    (core_data),
        .core_we      (core_we),
        .fill_start   (fill_start),
        .fill_base    (fill_base),
        .fill_count   (fill_count),
        .fill_data    (fill_data),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .core_overflow(core_overflow),
        .vm_addr      (vm_addr),
        .vm_data      (vm_data),
        .vm_we        (vm_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cwe;
        logic [31:0] caddr;
        logic [31:0] cdata;
        logic        fs;
        logic [31:0] fb;
        logic [15:0] fc;
        logic [31:0] fd;
        logic        ewe;
        logic [31:0] eaddr;
        logic [31:0] edata;
        logic        ebusy;
        logic        edone;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (we,addr,data,busy,done,ovf)", nm, act, exp);
        end
    endtask

    function automatic logic [67:0] outs();
        return {vm_we, vm_addr, vm_data, fill_busy, fill_done, core_overflow};
    endfunction

    task automatic add(input logic cwe, input logic [31:0] ca, input logic [31:0] cd,
                       input logic fs, input logic [31:0] fb, input logic [15:0] fc,
                       input logic [31:0] fd, input logic ewe, input logic [31:0] ea,
                       input logic [31:0] ed, input logic eb, input logic edn);
        vec_t v;
        v.cwe = cwe; v.caddr = ca; v.cdata = cd;
        v.fs = fs; v.fb = fb; v.fc = fc; v.fd = fd;
        v.ewe = ewe; v.eaddr = ea; v.edata = ed; v.ebusy = eb; v.edone = edn;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        core_we = 1'b0; core_addr = '0; core_data = '0;
        fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_data = '0;
    endtask

    // Called at a negedge: reset for two cycles, release on a negedge.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Called at a negedge: checks each row's outputs, then drives its inputs.
    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            chk($sformatf("%s row %0d", tag, i), outs(),
                {vq[i].ewe, vq[i].eaddr, vq[i].edata, vq[i].ebusy, vq[i].edone, 1'b0});
            core_we = vq[i].cwe; core_addr = vq[i].caddr; core_data = vq[i].cdata;
            fill_start = vq[i].fs; fill_base = vq[i].fb;
            fill_count = vq[i].fc; fill_data = vq[i].fd;
            @(negedge clk);
        end
        vq.delete();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // ---- Table 1: single store, fill of 4, fill of 0, wrap, ignored start
        //   cwe addr   data   fs  base          cnt  fdata         we addr          data          b  d
        add(1, 32'h100, 32'hAB, 0, 0, 0, 0,                        0, 0,            0,            0, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         0, 0,            0,            0, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         1, 32'h100,      32'hAB,       0, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         0, 32'h100,      32'hAB,       0, 0);
        add(0, 0, 0, 1, 32'h2000, 16'd4, 32'hFFFF0000,             0, 32'h100,      32'hAB,       0, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         0, 32'h100,      32'hAB,       1, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         1, 32'h2000,     32'hFFFF0000, 1, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         1, 32'h2004,     32'hFFFF0000, 1, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         1, 32'h2008,     32'hFFFF0000, 1, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         1, 32'h200C,     32'hFFFF0000, 1, 1);
        add(0, 0, 0, 1, 32'h5000, 16'd0, 32'h11,                   0, 32'h200C,     32'hFFFF0000, 0, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         0, 32'h200C,     32'hFFFF0000, 1, 1);
        add(0, 0, 0, 1, 32'hFFFFFFF8, 16'd3, 32'h33,               0, 32'h200C,     32'hFFFF0000, 0, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         0, 32'h200C,     32'hFFFF0000, 1, 0);
        add(0, 0, 0, 1, 32'h9000, 16'd5, 32'h99,                   1, 32'hFFFFFFF8, 32'h33,       1, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         1, 32'hFFFFFFFC, 32'h33,       1, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         1, 32'h00000000, 32'h33,       1, 1);
        add(0, 0, 0,           0, 0, 0, 0,                         0, 32'h00000000, 32'h33,       0, 0);
        add(0, 0, 0,           0, 0, 0, 0,                         0, 32'h00000000, 32'h33,       0, 0);
        run_table("basic");

        // ---- Table 2: core store every cycle against a fill of 4.
        // Ties alternate, and the core wins regardless at occupancy 3.
        do_reset();
        add(1, 32'h400, 32'hC0, 1, 32'h3000, 16'd4, 32'hF0,        0, 0,        0,      0, 0);
        add(1, 32'h404, 32'hC1, 0, 0, 0, 0,                        0, 0,        0,      1, 0);
        add(1, 32'h408, 32'hC2, 0, 0, 0, 0,                        1, 32'h400,  32'hC0, 1, 0);
        add(1, 32'h40C, 32'hC3, 0, 0, 0, 0,                        1, 32'h3000, 32'hF0, 1, 0);
        add(1, 32'h410, 32'hC4, 0, 0, 0, 0,                        1, 32'h404,  32'hC1, 1, 0);
        add(1, 32'h414, 32'hC5, 0, 0, 0, 0,                        1, 32'h3004, 32'hF0, 1, 0);
        add(0, 0, 0,            0, 0, 0, 0,                        1, 32'h408,  32'hC2, 1, 0);
        add(0, 0, 0,            0, 0, 0, 0,                        1, 32'h40C,  32'hC3, 1, 0);
        add(0, 0, 0,            0, 0, 0, 0,                        1, 32'h3008, 32'hF0, 1, 0);
        add(0, 0, 0,            0, 0, 0, 0,                        1, 32'h410,  32'hC4, 1, 0);
        add(0, 0, 0,            0, 0, 0, 0,                        1, 32'h300C, 32'hF0, 1, 1);
        add(0, 0, 0,            0, 0, 0, 0,                        1, 32'h414,  32'hC5, 0, 0);
        add(0, 0, 0,            0, 0, 0, 0,                        0, 32'h414,  32'hC5, 0, 0);
        run_table("contend");

        // ---- Fill of 8 with a core store every other cycle. Core write k
        // lands at cycle 2k+2 and fill write j at cycle 2j+3.
        do_reset();
        for (int r = 0; r < 20; r++) begin
            logic        ewe;
            logic [31:0] ea;
            logic [31:0] ed;
            ewe = (r >= 2) && (r <= 17);
            ea  = '0;
            ed  = '0;
            if (ewe && (r % 2 == 0)) begin
                ea = 32'h700 + 32'(4 * ((r - 2) / 2));
                ed = 32'((r - 2) / 2);
            end else if (ewe) begin
                ea = 32'h6000 + 32'(4 * ((r - 3) / 2));
                ed = 32'h77;
            end
            if (ewe) begin
                chk($sformatf("interleave row %0d", r), outs(),
                    {1'b1, ea, ed, 1'b1, (r == 17), 1'b0});
            end else begin
                chk($sformatf("interleave row %0d", r),
                    {64'd0, vm_we, fill_busy, fill_done, core_overflow},
                    {64'd0, 1'b0, (r == 1), 1'b0, 1'b0});
            end
            idle_inputs();
            if (r == 0) begin
                fill_start = 1'b1; fill_base = 32'h6000;
                fill_count = 16'd8; fill_data = 32'h77;
            end
            if ((r % 2 == 0) && (r <= 14)) begin
                core_we = 1'b1;
                core_addr = 32'h700 + 32'(2 * r);
                core_data = 32'(r / 2);
            end
            @(negedge clk);
        end

        // ---- Asynchronous reset mid-fill with two stores queued
        do_reset();
        for (int r = 0; r < 4; r++) begin
            idle_inputs();
            core_we = 1'b1; core_addr = 32'hA00 + 32'(4 * r); core_data = 32'hD0 + 32'(r);
            if (r == 0) begin
                fill_start = 1'b1; fill_base = 32'h8000;
                fill_count = 16'd10; fill_data = 32'h88;
            end
            @(negedge clk);
        end
        idle_inputs();
        chk("pre-reset busy", {67'd0, fill_busy}, {67'd0, 1'b1});
        #2 rst = 1'b0;
        #1 chk("async reset outs", outs(), 68'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 10; r++) begin
            chk($sformatf("post-reset row %0d", r),
                {64'd0, vm_we, fill_busy, fill_done, core_overflow}, 68'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
